// File: rtl/dmem_resp_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets and bit positions.
package dmem_resp_pkg;

  typedef enum logic [3:0] {
    MMIO_SCRATCH   = 4'h0,
    MMIO_CYCLE_LO  = 4'h1,
    MMIO_CYCLE_HI  = 4'h2,
    MMIO_CONS_STAT = 4'h3,
    MMIO_CONS_DATA = 4'h4,
    MMIO_HALT      = 4'h5
  } mmio_off_e;

  localparam int unsigned REGION_BIT   = 13;
  localparam int unsigned CONS_OVF_BIT = 31;

endpackage

// File: rtl/cons_fifo.sv
// Console byte FIFO; a push while full is still accepted when a pop happens in the same cycle.
module cons_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   full,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Gated so the head reads zero whenever nothing is queued.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory SRAM-port responder: RAM below A[13], MMIO (scratch, cycle, console, halt) above.
// Define DMEM_CYCLE_CNT_EN to include the 64-bit cycle counter and its hi shadow.
module dmem_mmio_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned RAM_DEPTH  = 8192,
  parameter int unsigned CONS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CS,
  input  logic        OE,
  input  logic [3:0]  WEB,
  input  logic [13:0] A,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
  localparam int unsigned CNT_W  = $clog2(CONS_DEPTH) + 1;

  logic [31:0]       mem [RAM_DEPTH];
  logic [RAM_AW-1:0] ram_idx;
  logic              rd_en, wr_en, mmio_sel, ram_wr;
  logic [31:0]       rd_data, stat_word;
  logic [31:0]       do_q, scratch_q, halt_code_q;
  logic              halt_q, overflow_q;
  logic              cons_push, cons_pop, cons_full, cons_empty;
  logic [CNT_W-1:0]  cons_count;
`ifdef DMEM_CYCLE_CNT_EN
  logic [63:0]       cycle_q;
  logic [31:0]       hi_shadow_q;
`endif

  assign ram_idx  = A[RAM_AW-1:0];
  assign mmio_sel = A[REGION_BIT];
  // Any low WEB bit makes this a write; OE only matters when no byte is enabled.
  assign wr_en    = CS & (WEB != 4'hF) & ~rst;
  assign rd_en    = CS & OE & (WEB == 4'hF);
  assign ram_wr   = wr_en & ~mmio_sel;

  assign cons_push  = wr_en & mmio_sel & (A[3:0] == MMIO_CONS_DATA) & ~WEB[0];
  assign cons_valid = ~cons_empty;
  assign cons_pop   = cons_valid & cons_ready;

  cons_fifo #(
    .WIDTH (8),
    .DEPTH (CONS_DEPTH)
  ) u_cons_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cons_push),
    .push_data (DI[7:0]),
    .full      (cons_full),
    .pop       (cons_pop),
    .head      (cons_data),
    .empty     (cons_empty),
    .count     (cons_count)
  );

  always_comb begin
    stat_word               = '0;
    stat_word[CONS_OVF_BIT] = overflow_q;
    stat_word[7:0]          = 8'(cons_count);
  end

  always_comb begin
    rd_data = '0;
    if (mmio_sel) begin
      case (A[3:0])
        MMIO_SCRATCH:   rd_data = scratch_q;
`ifdef DMEM_CYCLE_CNT_EN
        MMIO_CYCLE_LO:  rd_data = cycle_q[31:0];
        MMIO_CYCLE_HI:  rd_data = hi_shadow_q;
`endif
        MMIO_CONS_STAT: rd_data = stat_word;
        default:        rd_data = '0;
      endcase
    end else begin
      rd_data = mem[ram_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (!WEB[i]) mem[ram_idx][8*i +: 8] <= DI[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      do_q        <= '0;
      scratch_q   <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      overflow_q  <= 1'b0;
`ifdef DMEM_CYCLE_CNT_EN
      cycle_q     <= '0;
      hi_shadow_q <= '0;
`endif
    end else begin
`ifdef DMEM_CYCLE_CNT_EN
      cycle_q <= cycle_q + 64'd1;
      if (rd_en && mmio_sel && (A[3:0] == MMIO_CYCLE_LO)) hi_shadow_q <= cycle_q[63:32];
`endif
      if (rd_en) do_q <= rd_data;
      if (wr_en && mmio_sel && (A[3:0] == MMIO_SCRATCH)) begin
        for (int i = 0; i < 4; i++) begin
          if (!WEB[i]) scratch_q[8*i +: 8] <= DI[8*i +: 8];
        end
      end
      if (wr_en && mmio_sel && (A[3:0] == MMIO_HALT)) begin
        halt_q      <= 1'b1;
        halt_code_q <= DI;
      end
      // A dropped push wins over a same-cycle status read.
      if (cons_push && cons_full && !cons_pop) begin
        overflow_q <= 1'b1;
      end else if (rd_en && mmio_sel && (A[3:0] == MMIO_CONS_STAT)) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign DO        = do_q;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed self-checking bench for dmem_mmio_responder; expectations are hand-computed constants.
module tb_dmem_mmio_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CS = 1'b0;
  logic        OE = 1'b0;
  logic [3:0]  WEB = 4'hF;
  logic [13:0] A = '0;
  logic [31:0] DI = '0;
  logic [31:0] DO;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready = 1'b0;
  logic        halt;
  logic [31:0] halt_code;

  int errors = 0;
  int checks = 0;

  dmem_mmio_responder dut (
    .clk        (clk),
    .rst        (rst),
    .CS         (CS),
    .OE         (OE),
    .WEB        (WEB),
    .A          (A),
    .DI         (DI),
    .DO         (DO),
    .cons_valid (cons_valid),
    .cons_data  (cons_data),
    .cons_ready (cons_ready),
    .halt       (halt),
    .halt_code  (halt_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] web);
    @(negedge clk);
    CS = 1'b1; OE = 1'b0; WEB = web; A = a; DI = d;
    @(posedge clk); #1;
    CS = 1'b0; WEB = 4'hF;
  endtask

  task automatic do_read(input logic [13:0] a);
    @(negedge clk);
    CS = 1'b1; OE = 1'b1; WEB = 4'hF; A = a;
    @(posedge clk); #1;
    CS = 1'b0; OE = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_do"}, DO, 32'h0);
    check({tag, "_valid"}, {31'b0, cons_valid}, 32'h0);
    check({tag, "_cdata"}, {24'b0, cons_data}, 32'h0);
    check({tag, "_halt"}, {31'b0, halt}, 32'h0);
    check({tag, "_hcode"}, halt_code, 32'h0);
  endtask

  logic [31:0] exp_cyc;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;

    do_read(14'h2003);
    check("stat_after_reset", DO, 32'h0);
    do_read(14'h2000);
    check("scratch_after_reset", DO, 32'h0);

    // RAM byte writes and read-after-write
    do_write(14'h0010, 32'hAABBCCDD, 4'h0);
    do_write(14'h0010, 32'h00000011, 4'b1110);
    do_read(14'h0010);
    check("ram_bytes", DO, 32'hAABBCC11);
    do_write(14'h0020, 32'h55555555, 4'h0);
    check("do_holds_on_write", DO, 32'hAABBCC11);
    do_read(14'h0020);
    check("ram_second_word", DO, 32'h55555555);

    // Scratch, aliasing, unmapped offsets, CS gating
    do_write(14'h2000, 32'h12345678, 4'h0);
    do_read(14'h2010);
    check("scratch_alias", DO, 32'h12345678);
    do_read(14'h2007);
    check("unmapped_zero", DO, 32'h0);
    do_write(14'h2000, 32'hFFFFFFFF, 4'b0111);
    do_read(14'h2000);
    check("scratch_byte3", DO, 32'hFF345678);
    @(negedge clk);
    CS = 1'b0; WEB = 4'h0; A = 14'h2000; DI = 32'h0;
    @(posedge clk); #1;
    WEB = 4'hF;
    do_read(14'h2000);
    check("cs_low_no_write", DO, 32'hFF345678);
    do_read(14'h2004);
    check("wo_cons_data_reads_zero", DO, 32'h0);

    // Console push and drain
    do_write(14'h2004, 32'h00000048, 4'b1110);
    do_write(14'h2004, 32'h00000069, 4'b1110);
    do_read(14'h2003);
    check("cons_stat_two", DO, 32'h2);
    check("cons_valid_up", {31'b0, cons_valid}, 32'h1);
    @(negedge clk); cons_ready = 1'b1;
    check("cons_head_H", {24'b0, cons_data}, 32'h48);
    @(posedge clk); #1;
    check("cons_head_i", {24'b0, cons_data}, 32'h69);
    @(posedge clk); #1;
    check("cons_valid_drop", {31'b0, cons_valid}, 32'h0);
    @(negedge clk); cons_ready = 1'b0;

    // Overflow on the ninth push
    for (int i = 1; i <= 9; i++) do_write(14'h2004, 32'(i), 4'b1110);
    do_read(14'h2003);
    check("overflow_stat", DO, 32'h80000008);
    do_read(14'h2003);
    check("overflow_cleared", DO, 32'h00000008);
    check("cons_head_first", {24'b0, cons_data}, 32'h01);

    // Push into full FIFO while popping
    @(negedge clk);
    cons_ready = 1'b1; CS = 1'b1; OE = 1'b0; WEB = 4'b1110; A = 14'h2004; DI = 32'h7A;
    @(posedge clk); #1;
    CS = 1'b0; WEB = 4'hF;
    @(negedge clk); cons_ready = 1'b0;
    do_read(14'h2003);
    check("full_pop_push_stat", DO, 32'h00000008);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); cons_ready = 1'b1;
      check($sformatf("drain_%0d", i), {24'b0, cons_data}, (i < 7) ? 32'(i + 2) : 32'h7A);
    end
    @(posedge clk); #1;
    check("drain_empty", {31'b0, cons_valid}, 32'h0);
    @(negedge clk); cons_ready = 1'b0;

    // Halt
    do_write(14'h2005, 32'h00000001, 4'b0111);
    check("halt_set", {31'b0, halt}, 32'h1);
    check("halt_code_1", halt_code, 32'h1);
    do_write(14'h2005, 32'hDEADBEEF, 4'b1110);
    check("halt_code_update", halt_code, 32'hDEADBEEF);
    do_write(14'h2004, 32'h00000033, 4'b1110);
    do_read(14'h0020);
    check("pre_reset_valid", {31'b0, cons_valid}, 32'h1);

    // Reset mid-operation, then cycle counter
    @(negedge clk);
    rst = 1'b1; CS = 1'b1; WEB = 4'h0; A = 14'h2000; DI = 32'hCAFEF00D;
    @(posedge clk); #1;
    CS = 1'b0; WEB = 4'hF;
    check_reset_outputs("mid_reset");
    @(negedge clk); rst = 1'b0;
    repeat (100) @(posedge clk);
`ifdef DMEM_CYCLE_CNT_EN
    exp_cyc = 32'd100;
`else
    exp_cyc = 32'd0;
`endif
    do_read(14'h2001);
    check("cycle_lo", DO, exp_cyc);
    do_read(14'h2002);
    check("cycle_hi", DO, 32'h0);
    do_read(14'h2000);
    check("scratch_reset_write_dropped", DO, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
